hex_display_driver: RTL



---
 rtl/hex_display_pkg.sv | 33 +++
 rtl/hex_display_driver_seg7_encode.sv | 24 ++
 rtl/hex_display_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display driver.
//   state_t            : conversion FSM state (IDLE, CONVERT, DONE)
//   SEG_BLANK/SEG_DASH : active-low segment patterns for an unlit digit and a lone 'g' segment
//   SEG_TABLE          : BCD nibble -> active-low pattern (bit0=a .. bit6=g); 10..15 map to dash
//   max_display_value  : largest value that fits in a given number of decimal digits
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  // 10^digits - 1, evaluated at elaboration time for the overflow compare.
  function automatic logic [31:0] max_display_value(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/hex_display_driver_seg7_encode.sv
// One-digit seven-segment encoder (purely combinational).
//   bcd   : decimal digit 0..9 (10..15 show a dash)
//   blank : digit is a suppressed leading zero -> all segments off
//   dash  : overflow indication -> dash, takes priority over blank
//   seg   : active-low segments, bit0=a .. bit6=g
module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[bcd];
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/hex_display_driver.sv
// Binary to six-digit seven-segment display driver.
// A value is taken over a valid/ready handshake, converted to BCD by
// shift-add-3 (one input bit per clock), then encoded and registered onto
// the HEX outputs. Outputs hold until the next conversion completes.
//
// Handshake: a transfer happens on a rising clock edge where io_in_valid and
// io_in_ready are both high. io_in_ready is high only in IDLE; while it is
// low io_in_valid is ignored and nothing is queued, the upstream simply
// holds its value until ready returns.
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   io_in_valid/ready/bits: input handshake, unsigned binary value
//   io_busy               : conversion in progress (state != IDLE)
//   io_overflow           : registered, last accepted value exceeded 10^DIGITS-1
//   io_hex_0..io_hex_5    : active-low segments, io_hex_0 = least significant digit
//   io_state              : current FSM state, for observation
// The six HEX ports are wired to digits 0..5, so DIGITS must be at least 6.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int WIDTH         = 20,
  parameter int DIGITS        = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_busy,
  output logic             io_overflow,
  output logic [6:0]       io_hex_0,
  output logic [6:0]       io_hex_1,
  output logic [6:0]       io_hex_2,
  output logic [6:0]       io_hex_3,
  output logic [6:0]       io_hex_4,
  output logic [6:0]       io_hex_5,
  output state_t           io_state
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX_VAL = max_display_value(DIGITS);

  state_t           state;
  logic [WIDTH-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_pending_q;
  logic [6:0]       hex_q [DIGITS];

  logic [BCD_W-1:0] bcd_adj;
  logic [DIGITS-1:0] digit_blank;
  logic [6:0]       seg_next [DIGITS];

  // Add-3 correction: any nibble >= 5 would become >= 10 after the doubling
  // shift, so it is pre-biased to carry correctly into the next nibble.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  // Digit 0 is never blanked so that a value of zero still shows "0".
  always_comb begin
    logic zero_above;
    logic zero_from_here;
    zero_above     = 1'b1;
    zero_from_here = 1'b1;
    digit_blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from_here = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      digit_blank[i] = (BLANK_LEADING != 0) && (i != 0) && zero_from_here;
      zero_above     = zero_from_here;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .bcd   (bcd_q[4*g +: 4]),
      .blank (digit_blank[g]),
      .dash  (ovf_pending_q),
      .seg   (seg_next[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bin_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      ovf_pending_q <= 1'b0;
      io_overflow   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            bin_q         <= io_in_bits;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 32'(io_in_bits) > MAX_VAL;
            state         <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          hex_q       <= seg_next;
          io_overflow <= ovf_pending_q;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io_in_ready = (state == IDLE);
  assign io_busy     = (state != IDLE);
  assign io_state    = state;

  assign io_hex_0 = hex_q[0];
  assign io_hex_1 = hex_q[1];
  assign io_hex_2 = hex_q[2];
  assign io_hex_3 = hex_q[3];
  assign io_hex_4 = hex_q[4];
  assign io_hex_5 = hex_q[5];

endmodule
